// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and helpers used by the line-fill master and its bench.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Normal non-cacheable bufferable memory.
  localparam logic [3:0] AXI_CACHE_NORMAL = 4'b0011;

  // AxSIZE encoding for a beat of 'bytes' bytes (bytes is a power of two, 1..128).
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] size;
    size = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_line_fill_master.sv
// AXI4 read master: one cache-line fill request becomes one INCR burst; the
// returned beats are assembled into a line buffer and handed back with an
// error flag covering bad responses, wrong IDs and burst-length violations.
module axi_line_fill_master
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  // Fill request / response side
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] resp_data,
  output logic                             resp_err,
  // AXI4 read address channel
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  // AXI4 read data channel
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int unsigned LINE_BYTES = LINE_BEATS * DATA_WIDTH / 8;
  // One extra bit so the counter can sit at LINE_BEATS and flag surplus beats.
  localparam int unsigned CNT_W      = $clog2(LINE_BEATS) + 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ID_WIDTH-1:0]   ARID     = ID_WIDTH'(AXI_ID);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(LINE_BEATS);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(LINE_BEATS - 1);
  localparam logic [2:0]            AR_SIZE  = axi_size(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } fill_state_e;

  fill_state_e                           state_q, state_d;
  logic                                  req_ready_q, req_ready_d;
  logic                                  arvalid_q, arvalid_d;
  logic                                  rready_q, rready_d;
  logic                                  resp_valid_q, resp_valid_d;
  logic                                  err_q, err_d;
  logic [CNT_W-1:0]                      beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]                 araddr_q, araddr_d;
  logic [LINE_BEATS-1:0][DATA_WIDTH-1:0] line_q, line_d;

  // Next-state and next-output logic for the fill sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    beat_cnt_d   = beat_cnt_q;
    araddr_d     = araddr_q;
    line_d       = line_q;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          araddr_d    = req_addr & ~OFF_MASK;
          err_d       = 1'b0;
          beat_cnt_d  = '0;
          arvalid_d   = 1'b1;
          state_d     = S_ADDR;
        end
      end

      S_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (m_axi_rvalid && rready_q) begin
          if (beat_cnt_q < CNT_FULL) begin
            for (int k = 0; k < int'(LINE_BEATS); k++) begin
              if (beat_cnt_q == CNT_W'(k)) line_d[k] = m_axi_rdata;
            end
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            // Surplus beat beyond the line: dropped, line marked unreliable.
            err_d = 1'b1;
          end
          if (m_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (m_axi_rid != ARID)            err_d = 1'b1;
          if (m_axi_rlast && (beat_cnt_q != CNT_LAST)) err_d = 1'b1;
          // Only rlast ends the burst, so a short burst leaves stale beats behind.
          if (m_axi_rlast) begin
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      beat_cnt_q   <= '0;
      araddr_q     <= '0;
      // NOTE: the line buffer is reset because resp_data must read zero out
      // of reset and short bursts expose whatever the buffer already holds.
      line_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state.
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      beat_cnt_q   <= beat_cnt_d;
      araddr_q     <= araddr_d;
      line_q       <= line_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = line_q;
  assign resp_err      = err_q;

  assign m_axi_arid    = ARID;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(LINE_BEATS - 1);
  assign m_axi_arsize  = AR_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_NORMAL;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
